// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian RAM behind a valid/ready request port.
// Fixed LATENCY per request. The optional memory-mapped output register is enabled by DMEM_MMIO_EN.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  byte_op_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
`ifdef DMEM_MMIO_EN
    ,
    output logic [DATA_WIDTH-1:0] mmio_o
`endif
);

    // Handshake: a request is taken on a rising edge where req_valid_i && req_ready_o.
    // rsp_valid_o is high for exactly one cycle per taken request and qualifies rdata_o/err_o.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  byte_q, byte_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic                  accept;
    logic                  commit;
    logic [DATA_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_we;
    logic                  c_byte;
    logic                  misaligned;
    logic                  mmio_hit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign accept      = req_valid_i && req_ready_o;

    // With LATENCY=1 the commit edge is the accept edge, so commit sources the live inputs.
    assign c_addr  = (state_q == S_IDLE) ? addr_i    : addr_q;
    assign c_wdata = (state_q == S_IDLE) ? wdata_i   : wdata_q;
    assign c_we    = (state_q == S_IDLE) ? we_i      : we_q;
    assign c_byte  = (state_q == S_IDLE) ? byte_op_i : byte_q;

    assign a0 = c_addr[ADDR_WIDTH-1:0];
    assign a1 = a0 + ADDR_WIDTH'(1);
    assign a2 = a0 + ADDR_WIDTH'(2);
    assign a3 = a0 + ADDR_WIDTH'(3);

    assign misaligned = !c_byte && (c_addr[1:0] != 2'b00);

`ifdef DMEM_MMIO_EN
    logic [DATA_WIDTH-1:0] mmio_q, mmio_d;
    localparam logic [DATA_WIDTH-1:0] MMIO_ADDR = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    assign mmio_hit = (c_addr == MMIO_ADDR);
    assign mmio_o   = mmio_q;

    always_comb begin
        mmio_d = mmio_q;
        if (commit && c_we && mmio_hit) begin
            if (c_byte) mmio_d = {mmio_q[DATA_WIDTH-1:8], c_wdata[7:0]};
            else        mmio_d = c_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mmio_q <= '0;
        else     mmio_q <= mmio_d;
    end
`else
    logic unused_addr_bits;
    assign mmio_hit         = 1'b0;
    assign unused_addr_bits = ^c_addr[DATA_WIDTH-1:ADDR_WIDTH];
`endif

    assign mem_we = commit && c_we && !misaligned && !mmio_hit;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = we_i;
                    byte_d  = byte_op_i;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        count_d = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response data is captured on the commit edge and then held until the next commit.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = misaligned;
            rdata_d = '0;
            if (!c_we && !misaligned) begin
`ifdef DMEM_MMIO_EN
                if (mmio_hit)
                    rdata_d = c_byte ? {{(DATA_WIDTH-8){1'b0}}, mmio_q[7:0]} : mmio_q;
                else
`endif
                if (c_byte)
                    rdata_d = {{(DATA_WIDTH-8){1'b0}}, mem[a0]};
                else
                    rdata_d = {mem[a3], mem[a2], mem[a1], mem[a0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[a0] <= c_wdata[7:0];
            if (!c_byte) begin
                mem[a1] <= c_wdata[15:8];
                mem[a2] <= c_wdata[23:16];
                mem[a3] <= c_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset, word/byte access, misalignment, wrap/alias, reset mid-op, MMIO.
module tb_dmem_responder;

`ifdef DMEM_MMIO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        byte_op_i = 1'b0;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .we_i       (we_i),
        .byte_op_i  (byte_op_i),
        .rsp_valid_o(rsp_valid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_o     (mmio_o)
`endif
    );

    // Driver: issue one request, return response data, latency in cycles and rsp_valid one cycle later.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic bo,
                          output logic [31:0] rd, output logic er, output int lat, output logic v_after);
        @(negedge clk);
        addr_i = a; wdata_i = wd; we_i = we; byte_op_i = bo; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        wdata_i = 32'hBAD0_BAD0;
        lat = 1;
        while (rsp_valid_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_o;
        er = err_o;
        @(posedge clk); #1;
        v_after = rsp_valid_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
`ifdef DMEM_MMIO_EN
        n_cmp++; if (mmio_o !== 32'h0) begin n_bad++; $display("FAIL reset_mmio: got %h want 0", mmio_o); end
`endif
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; logic va;
        do_req(32'h10, 32'h1234_5678, 1'b1, 1'b0, rd, er, lat, va);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL store_rdata: got %h want 0", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b want 0", er); end
        n_cmp++; if (va !== 1'b0) begin n_bad++; $display("FAIL store_rsp_one_cycle: got %b want 0", va); end
        do_req(32'h10, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL load_word: got %h want 12345678", rd); end
        n_cmp++; if (rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL rdata_hold: got %h want 12345678", rdata_o); end
    endtask

    task automatic test_byte_ops();
        logic [31:0] rd; logic er; int lat; logic va;
        do_req(32'h13, 32'hFFFF_FFAB, 1'b1, 1'b1, rd, er, lat, va);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_byte_err: got %b want 0", er); end
        do_req(32'h10, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== 32'hAB34_5678) begin n_bad++; $display("FAIL byte_merge_word: got %h want ab345678", rd); end
        do_req(32'h13, 32'h0, 1'b0, 1'b1, rd, er, lat, va);
        n_cmp++; if (rd !== 32'h0000_00AB) begin n_bad++; $display("FAIL load_byte_13: got %h want 000000ab", rd); end
        do_req(32'h10, 32'h0, 1'b0, 1'b1, rd, er, lat, va);
        n_cmp++; if (rd !== 32'h0000_0078) begin n_bad++; $display("FAIL load_byte_10: got %h want 00000078", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat; logic va;
        do_req(32'h12, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misaligned_load_err: got %b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL misaligned_load_rdata: got %h want 0", rd); end
        do_req(32'h12, 32'hCAFE_F00D, 1'b1, 1'b0, rd, er, lat, va);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misaligned_store_err: got %b want 1", er); end
        do_req(32'h10, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== 32'hAB34_5678) begin n_bad++; $display("FAIL misaligned_no_write: got %h want ab345678", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL aligned_err_clear: got %b want 0", er); end
        do_req(32'h11, 32'h0, 1'b0, 1'b1, rd, er, lat, va);
        n_cmp++; if (rd !== 32'h56 || er !== 1'b0) begin n_bad++; $display("FAIL odd_byte_load: got %h/%b want 00000056/0", rd, er); end
    endtask

    task automatic test_wrap_alias();
        logic [31:0] rd; logic er; int lat; logic va;
        do_req(32'h0001_FFFC, 32'hA1B2_C3D4, 1'b1, 1'b0, rd, er, lat, va);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL top_word_err: got %b want 0", er); end
        do_req(32'h0003_FFFC, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== 32'hA1B2_C3D4) begin n_bad++; $display("FAIL alias_load: got %h want a1b2c3d4", rd); end
        do_req(32'h0001_FFFF, 32'h0, 1'b0, 1'b1, rd, er, lat, va);
        n_cmp++; if (rd !== 32'h0000_00A1) begin n_bad++; $display("FAIL top_byte_load: got %h want 000000a1", rd); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0; int t1 = -1; int t2 = -1;
        logic [31:0] d1 = '0; logic [31:0] d2 = '0;
        @(negedge clk);
        addr_i = 32'h10; we_i = 1'b0; byte_op_i = 1'b0; req_valid_i = 1'b1;
        while (t2 < 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid_o === 1'b1) begin
                if (t1 < 0) begin t1 = cyc; d1 = rdata_o; addr_i = 32'h0001_FFFC; end
                else begin t2 = cyc; d2 = rdata_o; end
            end
        end
        req_valid_i = 1'b0;
        n_cmp++; if (t1 !== LAT) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", t1, LAT); end
        n_cmp++; if (t2 - t1 !== LAT + 1) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, LAT + 1); end
        n_cmp++; if (d1 !== 32'hAB34_5678) begin n_bad++; $display("FAIL b2b_data1: got %h want ab345678", d1); end
        n_cmp++; if (d2 !== 32'hA1B2_C3D4) begin n_bad++; $display("FAIL b2b_data2: got %h want a1b2c3d4", d2); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat; logic va; int seen = 0;
        logic [31:0] want;
        do_req(32'h20, 32'h1122_3344, 1'b1, 1'b0, rd, er, lat, va);
        @(negedge clk);
        addr_i = 32'h20; wdata_i = 32'hDEAD_BEEF; we_i = 1'b1; byte_op_i = 1'b0; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_bad++; $display("FAIL midop_reset_outputs: got v=%b r=%b want v=0 r=1", rsp_valid_o, req_ready_o); end
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid_o === 1'b1) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid_o === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midop_no_rsp: got %0d pulses want 0", seen); end
        // With LATENCY=1 the write commits on the accept edge, before reset can intervene.
        want = (LAT == 1) ? 32'hDEAD_BEEF : 32'h1122_3344;
        do_req(32'h20, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== want) begin n_bad++; $display("FAIL midop_prior_contents: got %h want %h", rd, want); end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        logic [31:0] rd; logic er; int lat; logic va;
        do_req(32'hFFFF_FFFC, 32'h0000_0005, 1'b1, 1'b0, rd, er, lat, va);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mmio_latency: got %0d want 1", lat); end
        n_cmp++; if (mmio_o !== 32'h5) begin n_bad++; $display("FAIL mmio_word_store: got %h want 00000005", mmio_o); end
        do_req(32'h0001_FFFC, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== 32'hA1B2_C3D4) begin n_bad++; $display("FAIL mmio_ram_untouched: got %h want a1b2c3d4", rd); end
        do_req(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== 32'h5) begin n_bad++; $display("FAIL mmio_load: got %h want 00000005", rd); end
        do_req(32'hFFFF_FFFC, 32'h1234_567E, 1'b1, 1'b1, rd, er, lat, va);
        n_cmp++; if (mmio_o !== 32'h7E) begin n_bad++; $display("FAIL mmio_byte_store: got %h want 0000007e", mmio_o); end
    endtask
`else
    task automatic test_mmio_alias();
        logic [31:0] rd; logic er; int lat; logic va;
        do_req(32'hFFFF_FFFC, 32'h0000_0005, 1'b1, 1'b0, rd, er, lat, va);
        do_req(32'h0001_FFFC, 32'h0, 1'b0, 1'b0, rd, er, lat, va);
        n_cmp++; if (rd !== 32'h5) begin n_bad++; $display("FAIL high_addr_alias: got %h want 00000005", rd); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_ops();
        test_misaligned();
        test_wrap_alias();
        test_back_to_back();
        test_reset_midop();
`ifdef DMEM_MMIO_EN
        test_mmio();
`else
        test_mmio_alias();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
